packet_sender: RTL
==================

# packet_sender

Debug-driven Ethernet frame source: the transmit-side counterpart of the receive packet logger. A host fills a byte buffer through the JTAG debug-port register interface, then commands a send of N bytes, optionally repeated. The block streams the bytes to the RMII transmitter using the packet/advance handshake and pads short frames with zeros. It sits between `jtag_debug_port` and `eth_rmii_tx` in the `clk50` domain.

## Interface
- `BUF_BITS`, 11: buffer address width; the buffer holds 2^BUF_BITS bytes.
- `PAD_MIN`, 60: minimum frame length on the wire. Frames shorter than this are zero-padded; 0 disables padding.
- `clk50`  in  1  sole clock. One clock; all logic runs on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `dbg_wdata`  in  32  debug write data.
- `dbg_addr`  in  3  debug register index.
- `dbg_wr`  in  1  one-cycle write strobe.
- `dbg_rd`  in  1  one-cycle read strobe. No side effects in this block.
- `dbg_rdata`  out  32  combinational read data for `dbg_addr`.
- `tx_data`  out  8  current byte to the transmitter; registered.
- `tx_packet`  out  1  frame in progress; registered.
- `tx_advance`  in  1  transmitter consumed `tx_data`. Pulses are at least 2 cycles apart.
- `tx_busy`  in  1  transmitter still on the wire (FCS/IPG).

## Operation
- Registers, by `dbg_addr`:
  - 0: read 0x54585042; write has no effect.
  - 1: write stores `buf[wrptr] <= wdata[7:0]` and then `wrptr++`, wrapping modulo 2^BUF_BITS. The write is ignored while busy. Read returns {busy, 15'd0, sent[15:0]}.
  - 2: write sets `wrptr <= wdata[BUF_BITS-1:0]`. Read returns wrptr, zero-extended.
  - 3: write is a start command: `len <= wdata[BUF_BITS:0]`, `rpt <= wdata[31:16]`. The command is ignored if busy, if len==0, or if len>2^BUF_BITS. Read returns {rpt, 16'(len)}.
  - 4: write is an abort: `rpt <= 0`. A frame already on the wire is never truncated.
  - 5–7: read returns 0; write has no effect.
- `busy` = (state != IDLE).
- Frame length: `flen = max(len, PAD_MIN)`. Byte i of the frame is `buf[i]` for i<len and 0x00 otherwise.
- FSM states:
  - IDLE: a valid start goes to LOAD.
  - LOAD: one cycle. Loads `tx_data <= byte(0)` (sync RAM read) and sets `idx=0`. Goes to SEND.
  - SEND: `tx_packet=1`. On `tx_advance` with idx<flen-1: `idx++` and `tx_data <= byte(idx+1)` on the next cycle. On `tx_advance` with idx==flen-1: `tx_packet <= 0`, `sent++`, go to DRAIN.
  - DRAIN: wait until `tx_busy==0`, observed no earlier than the cycle after entry. Then, if rpt>0: `rpt--` and go to LOAD; otherwise go to IDLE.
- A start value of rpt=R produces R+1 frames.
- `sent` is 16 bits and wraps from 0xFFFF to 0.
- Reset state: IDLE, `tx_packet=0`, `tx_data=0`, wrptr=0, len=0, rpt=0, sent=0. Buffer contents are not reset.

## Timing
- Start write at edge T: LOAD during T+1. `tx_packet=1` and `tx_data=buf[0]` are visible from T+2.
- `tx_advance` sampled at edge A: the next byte is on `tx_data` from A+1. That is within the 2-cycle advance spacing.
- Last-byte advance at edge A: `tx_packet` is low from A+1; busy stays 1 through DRAIN.
- Repeat: the next frame's `tx_packet` rises 2 cycles after the cycle in which DRAIN first sees `tx_busy==0`.
- Abort during SEND: the current frame completes, then the FSM returns to IDLE.
- Abort during IDLE: no effect.
- Abort in the same cycle that DRAIN exits: rpt is already 0, so the FSM goes to IDLE.
- Reset mid-frame: `tx_packet` is 0 on the cycle after the reset edge, with no further advances honored.
- `dbg_rdata` reflects register state combinationally in the same cycle.

## Test plan
- Reset, then read addr0 -> 0x54585042. Read addr1 -> 0. Read addr2 -> 0.
- Write 64 bytes 0x00..0x3F via addr1, then start len=64, rpt=0, with the advance model pulsing every 4 cycles -> exactly 64 advances consumed, bytes 0x00..0x3F in order, `tx_packet` falls 1 cycle after the 64th advance, sent=1.
- Write 10 bytes, then start len=10 -> 60 bytes transmitted: 10 buffer bytes then 50×0x00.
- Start len=64, rpt=2, with `tx_busy` held 12 cycles after each frame -> 3 frames, gap timing per the Timing section, sent=3.
- Start len=64, rpt=5, abort during frame 2 -> frame 2 completes intact, no frame 3, sent=2.
- While busy: write addr1 and addr3 -> wrptr and len unchanged, no new frame. Then wrap test: wrptr=0x7FF, write 2 bytes -> wrptr=1.

Source files
------------

// File: rtl/packet_sender.sv
// packet_sender: debug-driven Ethernet frame source.
// A host fills a byte buffer through the debug register port and then
// commands a send of N bytes, optionally repeated. Bytes are streamed to
// the RMII transmitter with the packet/advance handshake, and frames
// shorter than PAD_MIN are zero-padded.
//
// Ports:
//   clk50       sole clock (rising edge)
//   reset       synchronous, active-high
//   dbg_wdata   debug write data
//   dbg_addr    debug register index
//   dbg_wr      one-cycle write strobe
//   dbg_rd      one-cycle read strobe (no side effects here)
//   dbg_rdata   combinational read data for dbg_addr
//   tx_data     current byte to the transmitter (registered)
//   tx_packet   frame in progress (registered)
//   tx_advance  transmitter consumed tx_data
//   tx_busy     transmitter still on the wire (FCS/IPG)
module packet_sender #(
  parameter int unsigned BUF_BITS = 11,
  parameter int unsigned PAD_MIN  = 60
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic [31:0] dbg_wdata,
  input  logic [2:0]  dbg_addr,
  input  logic        dbg_wr,
  input  logic        dbg_rd,
  output logic [31:0] dbg_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_packet,
  input  logic        tx_advance,
  input  logic        tx_busy
);

  localparam int unsigned   LW       = BUF_BITS + 1;
  localparam logic [LW-1:0] BUF_SIZE = LW'(2 ** BUF_BITS);
  localparam logic [LW-1:0] PAD_LEN  = LW'(PAD_MIN);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DRAIN} state_t;

  state_t state, state_n;

  logic [7:0]          mem [0:(2**BUF_BITS)-1];
  logic [BUF_BITS-1:0] wrptr;
  logic [LW-1:0]       len;
  logic [LW-1:0]       idx;
  logic [LW-1:0]       flen;
  logic [LW-1:0]       rd_idx;
  logic [LW-1:0]       cmd_len;
  logic [15:0]         rpt;
  logic [15:0]         sent;
  logic                drain_armed;

  logic busy, wr_buf, wr_ptr, start_ok, abort;
  logic last, rd_pad;
  logic do_load, do_step, do_finish, do_again;

  logic unused_ok;
  assign unused_ok = &{1'b0, dbg_rd, dbg_wdata};

  // Register decode
  assign busy     = (state != IDLE);
  assign cmd_len  = dbg_wdata[BUF_BITS:0];
  assign wr_buf   = dbg_wr && (dbg_addr == 3'd1) && !busy;
  assign wr_ptr   = dbg_wr && (dbg_addr == 3'd2);
  assign start_ok = dbg_wr && (dbg_addr == 3'd3) && !busy &&
                    (cmd_len != '0) && (cmd_len <= BUF_SIZE);
  assign abort    = dbg_wr && (dbg_addr == 3'd4);

  // Frame geometry: wire length is at least PAD_LEN, bytes past len are zero
  assign flen   = (len < PAD_LEN) ? PAD_LEN : len;
  assign last   = (idx == flen - LW'(1));
  assign rd_idx = do_load ? '0 : idx + LW'(1);
  assign rd_pad = (rd_idx >= len);

  always_ff @(posedge clk50) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    do_load   = 1'b0;
    do_step   = 1'b0;
    do_finish = 1'b0;
    do_again  = 1'b0;
    case (state)
      IDLE: if (start_ok) state_n = LOAD;
      LOAD: begin
        do_load = 1'b1;
        state_n = SEND;
      end
      SEND: if (tx_advance) begin
        if (last) begin
          do_finish = 1'b1;
          state_n   = DRAIN;
        end else begin
          do_step = 1'b1;
        end
      end
      DRAIN: if (drain_armed && !tx_busy) begin
        // An abort landing on the exit cycle wins over a pending repeat
        if (rpt != '0 && !abort) begin
          do_again = 1'b1;
          state_n  = LOAD;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Buffer write port; contents survive reset
  always_ff @(posedge clk50) begin
    if (wr_buf) mem[wrptr] <= dbg_wdata[7:0];
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      wrptr       <= '0;
      len         <= '0;
      rpt         <= '0;
      sent        <= '0;
      idx         <= '0;
      tx_data     <= '0;
      tx_packet   <= 1'b0;
      drain_armed <= 1'b0;
    end else begin
      // tx_busy is ignored on the first DRAIN cycle
      drain_armed <= (state == DRAIN);

      if (wr_buf)      wrptr <= wrptr + BUF_BITS'(1);
      else if (wr_ptr) wrptr <= dbg_wdata[BUF_BITS-1:0];

      if (start_ok) begin
        len <= cmd_len;
        rpt <= dbg_wdata[31:16];
      end else if (abort) begin
        rpt <= '0;
      end else if (do_again) begin
        rpt <= rpt - 16'd1;
      end

      if (do_load || do_step) begin
        tx_data <= rd_pad ? '0 : mem[rd_idx[BUF_BITS-1:0]];
        idx     <= rd_idx;
      end

      if (do_load) begin
        tx_packet <= 1'b1;
      end else if (do_finish) begin
        tx_packet <= 1'b0;
        sent      <= sent + 16'd1;
      end
    end
  end

  always_comb begin
    dbg_rdata = '0;
    case (dbg_addr)
      3'd0: dbg_rdata = 32'h5458_5042;
      3'd1: dbg_rdata = {busy, 15'd0, sent};
      3'd2: dbg_rdata[BUF_BITS-1:0] = wrptr;
      3'd3: dbg_rdata = {rpt, 16'(len)};
      default: dbg_rdata = '0;
    endcase
  end

endmodule
